// File: rtl/spi_frame_master.sv
// spi_frame_master
// SPI mode-0 master that shifts out one 32-bit command frame per accepted
// request and captures the 32 bits returned on MISO during the same frame.
// Frame layout: bit31 read flag, [30:26] target, [25:24] bank,
// [23:16] address, [15:0] data, sent MSB first.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   cmd_valid  command request
//   cmd_ready  block accepts a command this cycle
//   cmd_data   frame to transmit (sampled only at the handshake)
//   rsp_valid  one-cycle pulse, rsp_data is valid
//   rsp_data   MISO bits of the completed frame, first bit received in [31]
//   busy       high from handshake until the end of the inter-frame gap
//   M_SCK      SPI clock, idles low
//   M_MOSI     SPI data out
//   M_MISO     SPI data in, already synchronous to clk
//   M_CS       chip select, active low
module spi_frame_master #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic        M_SCK,
    output logic        M_MOSI,
    input  logic        M_MISO,
    output logic        M_CS
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    // Terminal counts for the per-state cycle counter.
    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
    localparam logic [15:0] GAP_LAST   = 16'(CS_GAP - 1);

    state_t      state, state_next;
    logic [15:0] cnt, cnt_next;
    logic [4:0]  bit_cnt, bit_cnt_next;
    logic [31:0] tx, tx_next;
    logic [31:0] rx, rx_next;
    logic        sck_next, mosi_next, cs_next;
    logic        ready_next, busy_next, rsp_valid_next;
    logic [31:0] rsp_data_next;

    // Every output is a flop so the SPI pins cannot glitch; the state
    // register and all outputs reset asynchronously to their idle values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            tx        <= '0;
            rx        <= '0;
            M_SCK     <= 1'b0;
            M_MOSI    <= 1'b0;
            M_CS      <= 1'b1;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            bit_cnt   <= bit_cnt_next;
            tx        <= tx_next;
            rx        <= rx_next;
            M_SCK     <= sck_next;
            M_MOSI    <= mosi_next;
            M_CS      <= cs_next;
            cmd_ready <= ready_next;
            busy      <= busy_next;
            rsp_valid <= rsp_valid_next;
            rsp_data  <= rsp_data_next;
        end
    end

    // Next-state and next-output logic. cnt counts cycles spent in the
    // current state (or SCK phase while shifting) and restarts at zero on
    // each transition.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt + 16'd1;
        bit_cnt_next   = bit_cnt;
        tx_next        = tx;
        rx_next        = rx;
        sck_next       = M_SCK;
        mosi_next      = M_MOSI;
        cs_next        = M_CS;
        rsp_valid_next = 1'b0;
        rsp_data_next  = rsp_data;

        case (state)
            IDLE: begin
                cnt_next = '0;
                if (cmd_valid && cmd_ready) begin
                    tx_next      = cmd_data;
                    mosi_next    = cmd_data[31];
                    cs_next      = 1'b0;
                    bit_cnt_next = '0;
                    state_next   = SETUP;
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == DIV_LAST) begin
                    cnt_next = '0;
                    sck_next = ~M_SCK;
                    if (!M_SCK) begin
                        // Rising SCK edge: capture MISO.
                        rx_next = {rx[30:0], M_MISO};
                    end else if (bit_cnt == 5'd31) begin
                        // Last falling edge: MOSI stays on bit 0.
                        state_next = HOLD;
                    end else begin
                        bit_cnt_next = bit_cnt + 5'd1;
                        tx_next      = {tx[30:0], 1'b0};
                        mosi_next    = tx[30];
                    end
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    cnt_next       = '0;
                    cs_next        = 1'b1;
                    mosi_next      = 1'b0;
                    rsp_data_next  = rx;
                    rsp_valid_next = 1'b1;
                    state_next     = GAP;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Registered ready/busy follow the state being entered, so ready is
        // low throughout reset and rises one clock after release.
        ready_next = (state_next == IDLE);
        busy_next  = (state_next != IDLE);
    end

endmodule

// File: doc/spi_frame_master.md
Name: spi_frame_master

Overview:
- SPI mode-0 master that sends one 32-bit command frame per accepted request and captures the 32 bits returned on MISO in the same frame.
- Drives the FPGA's slave SPI port (S_SCK/S_MOSI/S_MISO/S_CS) from an on-board loader or a test harness.
- Full-duplex: the read data for a register appears in the frame after the one that selects it.
- Frame format: bit31 read flag, [30:26] target index 0..23, [25:24] bank, [23:16] address, [15:0] data, sent MSB first.

Parameters:
- CLK_DIV, 4, SCK half-period in clk cycles (>=1).
- CS_SETUP, 2, clk cycles from CS falling to the first SCK rising edge (>=1).
- CS_HOLD, 2, clk cycles from the last SCK falling edge to CS rising (>=1).
- CS_GAP, 4, minimum clk cycles CS stays high between frames (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command this cycle.
- cmd_data  in  32  frame to transmit.
- rsp_valid  out  1  one-cycle pulse: rsp_data is valid.
- rsp_data  out  32  MISO bits captured in the completed frame, first bit received in [31].
- busy  out  1  high from handshake until the end of GAP.
- M_SCK  out  1  SPI clock, idles low.
- M_MOSI  out  1  SPI data out.
- M_MISO  in  1  SPI data in; bench must drive it already synchronous to clk.
- M_CS  out  1  chip select, active low.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: M_CS=1, M_SCK=0, M_MOSI=0, cmd_ready=0 while rst_n is low, rsp_valid=0, rsp_data=0, busy=0, state=IDLE.
- Reset asserted mid-frame forces these values immediately, without waiting for a clk edge.
- cmd_ready goes to 1 on the first clk after reset is released.
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch cmd_data into the TX shift register.
  - Next cycle: M_CS=0, M_MOSI=cmd_data[31], busy=1, cmd_ready=0, go to SETUP.
- SETUP: hold for CS_SETUP cycles with SCK low, then go to SHIFT.
- SHIFT, per bit:
  - SCK low for CLK_DIV cycles.
  - SCK rises; in the same clk edge M_MISO is sampled into the RX shift register (shift left, LSB in).
  - SCK high for CLK_DIV cycles.
  - SCK falls; MOSI advances to the next bit.
  - After the 32nd falling edge go to HOLD. MOSI is not advanced past bit0.
- HOLD:
  - CS_HOLD cycles with SCK=0, CS=0.
  - Then M_CS=1 and M_MOSI=0.
  - rsp_data is updated and rsp_valid pulses high for exactly one cycle, both on the cycle CS rises.
  - Go to GAP.
- GAP: CS_GAP cycles with CS high, then IDLE. busy drops on entry to IDLE.
- Timing:
  - CS low duration is exactly CS_SETUP + 64*CLK_DIV + CS_HOLD cycles.
  - Exactly 32 SCK rising edges per frame.
  - Minimum handshake-to-handshake interval is 1 + CS_SETUP + 64*CLK_DIV + CS_HOLD + CS_GAP cycles.
- cmd_valid while busy is ignored. No command queue. cmd_data is sampled only at the handshake.
- rsp_data holds its value until the next frame completes.
- No glitches: M_SCK, M_MOSI and M_CS are all driven from flops.

Test Plan:
- Single frame: CLK_DIV=2, cmd_data=32'hA5C3_0F1E.
  - MOSI sampled at each SCK rise gives A5C30F1E MSB-first.
  - Exactly 32 rising edges.
  - CS low for 132 cycles.
  - rsp_valid pulses once.
- Loopback: M_MISO tied to M_MOSI, cmd 32'h8B00_0000 -> rsp_data=32'h8B00_0000.
- Slave model returns 32'h0000_1234 -> rsp_data=32'h0000_1234 on the rsp_valid cycle, held afterwards.
- Back-to-back: cmd_valid held high with two commands.
  - Second handshake occurs exactly 1+2+128+2+4 cycles after the first.
  - CS high for >=4 cycles between frames.
  - cmd_ready=0 throughout the first frame.
- Reset mid-frame: rst_n low after the 10th SCK rising edge, between clk edges.
  - M_CS=1, M_SCK=0, M_MOSI=0 immediately.
  - No rsp_valid.
  - After release, a new command 32'h0123_4567 is sent complete and correct.
- Minimum timing: CLK_DIV=1, CS_SETUP=CS_HOLD=CS_GAP=1.
  - CS low for 66 cycles.
  - 32 SCK pulses, each high for 1 cycle.
  - Loopback data matches.
